secded_dec_engine: RTL
======================

Name: secded_dec_engine

Overview:
- Memory-side accelerator for program 2. It sits between the byte-wide data memory and the req/ack handshake of the top level.
- On a start pulse it reads N_MSG 16-bit Hamming SECDED words from data memory and corrects single-bit errors.
- It flags double-bit errors, writes the 11-bit payload plus status back to data memory, then pulses done.
- It consumes exactly what the program-1 encoder produces: bit 0 = overall parity p16; bits 15..1 = Hamming positions 15..1.

Parameters:
- SRC_BASE, 64: byte address of the first encoded word (low byte; high byte at +1).
- DST_BASE, 94: byte address of the first decoded result (low byte; high byte at +1).
- N_MSG, 15: number of words processed per start.
- AW, 8: memory address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- done  out  1  one-cycle ack pulse after the last write.
- mem_addr  out  AW  read/write byte address.
- mem_rd_data  in  8  read data; synchronous memory, valid the cycle after the address.
- mem_wr_en  out  1  write strobe; byte written at mem_addr on this edge.
- mem_wr_data  out  8  write data.
- n_single  out  4  count of single errors corrected in the last run.
- n_double  out  4  count of double errors flagged in the last run.

Behaviour:
- Reset values: state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, n_single=0, n_double=0, index=0.
- A reset mid-run aborts immediately. Bytes already written stay in memory; no further writes occur.
- States: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE.
  - IDLE: on start=1, go to RD_LO and clear index, n_single and n_double.
  - RD_LO: mem_addr=SRC_BASE+2*index.
  - RD_HI: capture mem_rd_data into lo; mem_addr=SRC_BASE+2*index+1.
  - CAP: form w={mem_rd_data,lo}, decode it, register the 16-bit result, update counters.
  - WR_LO: mem_wr_en=1, mem_addr=DST_BASE+2*index, data=result[7:0].
  - WR_HI: mem_wr_en=1, mem_addr=DST_BASE+2*index+1, data=result[15:8]. If index==N_MSG-1 go to DONE; else increment index and go to RD_LO.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency: 5 cycles per word. done is high in cycle 5*N_MSG+1 after the cycle in which start was sampled; 76 cycles at the default.
- start while not in IDLE is ignored. A start held high re-triggers only after returning to IDLE.
- mem_wr_en is 0 in every state other than WR_LO and WR_HI.
- Decode:
  - syndrome s[3:0] = XOR of the position indices k (1..15) where w[k]=1.
  - P = ^w (overall parity over all 16 bits).
  - P=0, s=0: no error.
  - P=1: single error. If s≠0, invert w[s]; if s=0 the error was p16 and no data change is made. Increment n_single.
  - P=0, s≠0: double error. Increment n_double; no correction.
- Payload extraction: d[1]=w[3], d[4:2]=w[7:5], d[11:5]=w[15:9].
- Result format:
  - Clean or single error: {5'b0, d[11:1]}.
  - Double error: {1'b1, 4'b0, raw d[11:1]}, where bit 15 is the double-error flag.
- Counters saturate at 15 and hold their values until the next start or reset.

Decomposition:
- Package secded_pkg: state enum (state_t); position constants; function extract_payload(w) returning 11 bits; result-flag constant DBL_FLAG=16'h8000.
- Sub-module secded_dec16: purely combinational. Input w[15:0]; outputs result[15:0], single, dbl. It is instantiated once in the engine.

Test Plan:
- Clean word: mem[64]=8'h0F, mem[65]=8'h00, start pulse -> mem[94]=8'h01, mem[95]=8'h00, n_single=0, n_double=0.
- Single data-bit error (bit 5): 16'h002F -> result 16'h0001, n_single=1.
- p16-only error: 16'h000E -> result 16'h0001, n_single=1.
- Double error (bits 5 and 9): 16'h022F -> result 16'h8013 with bit 15 set, n_double=1.
- Full run of 15 random encoded words, with 0/1/2 flips injected by a golden model -> all 30 destination bytes match the model; done pulses exactly once, in cycle 76; no writes outside 94..123.
- Handshake and reset:
  - start reasserted at cycle 20 -> ignored, still exactly one done.
  - reset asserted at cycle 30 -> done=0 and mem_wr_en=0 immediately; counters 0.
  - A following start completes a correct full run.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared types and helpers for the SECDED decode engine: FSM states, word geometry,
// syndrome computation and payload extraction for the 16-bit Hamming word.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CAP   = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int          WORD_W   = 16;
  localparam int          PAY_W    = 11;
  localparam int          SYN_W    = 4;
  localparam logic [15:0] DBL_FLAG = 16'h8000;

  // XOR of the Hamming position indices whose bit is set; bit 0 (p16) has no index.
  function automatic logic [SYN_W-1:0] syndrome(input logic [WORD_W-1:0] w);
    logic [SYN_W-1:0] s;
    s = 4'd0;
    for (int k = 1; k < WORD_W; k++) begin
      s = s ^ (w[k] ? 4'(k) : 4'd0);
    end
    return s;
  endfunction

  function automatic logic [PAY_W-1:0] extract_payload(input logic [WORD_W-1:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

endpackage

// File: rtl/secded_dec16.sv
// Combinational SECDED decoder for one 16-bit word: corrects single errors,
// flags double errors, and formats the 16-bit result word.
module secded_dec16
  import secded_pkg::*;
(
  input  logic [15:0] w,
  output logic [15:0] result,
  output logic        single,
  output logic        dbl
);

  logic [3:0]  syn_s;
  logic        par_s;
  logic [15:0] fixed_s;

  always_comb begin
    syn_s   = syndrome(w);
    par_s   = ^w;
    fixed_s = w;
    single  = 1'b0;
    dbl     = 1'b0;
    result  = {5'd0, extract_payload(w)};
    if (par_s) begin
      single = 1'b1;
      // A zero syndrome with odd parity means only p16 flipped; payload is intact.
      if (syn_s != 4'd0) begin
        fixed_s[syn_s] = ~w[syn_s];
      end else begin
        fixed_s = w;
      end
      result = {5'd0, extract_payload(fixed_s)};
    end else if (syn_s != 4'd0) begin
      dbl    = 1'b1;
      result = DBL_FLAG | {5'd0, extract_payload(w)};
    end else begin
      result = {5'd0, extract_payload(w)};
    end
  end

endmodule

// File: rtl/secded_dec_engine.sv
// Memory-side engine: reads N_MSG encoded words, decodes each with secded_dec16,
// writes the 16-bit results back byte by byte and pulses done.
module secded_dec_engine
  import secded_pkg::*;
#(
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 94,
  parameter int N_MSG    = 15,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    n_single,
  output logic [3:0]    n_double
);

  state_t          state_q, state_d;
  logic [3:0]      index_q, index_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      res_hi_q, res_hi_d;
  logic [3:0]      n_single_q, n_single_d;
  logic [3:0]      n_double_q, n_double_d;
  logic            done_q, done_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  logic [15:0]     dec_result_s;
  logic            dec_single_s;
  logic            dec_dbl_s;

  secded_dec16 u_dec (
    .w      ({mem_rd_data, lo_q}),
    .result (dec_result_s),
    .single (dec_single_s),
    .dbl    (dec_dbl_s)
  );

  // Next-state and next-output logic; outputs are registered so they line up with the state.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    lo_d       = lo_q;
    res_hi_d   = res_hi_q;
    n_single_d = n_single_q;
    n_double_d = n_double_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_LO;
          index_d    = 4'd0;
          n_single_d = 4'd0;
          n_double_d = 4'd0;
          addr_d     = AW'(SRC_BASE);
        end else begin
          state_d = IDLE;
        end
      end
      RD_LO: begin
        state_d = RD_HI;
        addr_d  = AW'(SRC_BASE + 2 * int'(index_q) + 1);
      end
      RD_HI: begin
        state_d = CAP;
        lo_d    = mem_rd_data;
      end
      CAP: begin
        state_d   = WR_LO;
        res_hi_d  = dec_result_s[15:8];
        wr_en_d   = 1'b1;
        addr_d    = AW'(DST_BASE + 2 * int'(index_q));
        wr_data_d = dec_result_s[7:0];
        if (dec_single_s && (n_single_q != 4'd15)) begin
          n_single_d = n_single_q + 4'd1;
        end else begin
          n_single_d = n_single_q;
        end
        if (dec_dbl_s && (n_double_q != 4'd15)) begin
          n_double_d = n_double_q + 4'd1;
        end else begin
          n_double_d = n_double_q;
        end
      end
      WR_LO: begin
        state_d   = WR_HI;
        wr_en_d   = 1'b1;
        addr_d    = AW'(DST_BASE + 2 * int'(index_q) + 1);
        wr_data_d = res_hi_q;
      end
      WR_HI: begin
        if (index_q == 4'(N_MSG - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_LO;
          index_d = index_q + 4'd1;
          addr_d  = AW'(SRC_BASE + 2 * (int'(index_q) + 1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      index_q    <= 4'd0;
      lo_q       <= 8'd0;
      res_hi_q   <= 8'd0;
      n_single_q <= 4'd0;
      n_double_q <= 4'd0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      lo_q       <= lo_d;
      res_hi_q   <= res_hi_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign done        = done_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign n_single    = n_single_q;
  assign n_double    = n_double_q;

endmodule
